// File: rtl/slug_ports.sv
`default_nettype none
// ============================================================================
// Module   : slug_ports
// Purpose  : Multi-channel port block. It synchronises the inputs, flags
//            per-channel changes, provides registered outputs and a masked
//            interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module slug_ports #(
  parameter int  DW   = 4,
  parameter int  NCH  = 8,
  parameter int  SYNC = 2,
  localparam int SW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SW-1:0]     sel,
  input  logic              wr_en,
  input  logic [DW-1:0]     wr_data,
  input  logic              rd_en,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  input  logic              ie_wr,
  input  logic [NCH-1:0]    ie_data,
  input  logic [NCH*DW-1:0] port_in,
  output logic [NCH*DW-1:0] port_out,
  output logic [NCH-1:0]    pend,
  output logic              irq
);

  localparam int PW = NCH * DW;

  logic [PW-1:0]  sync_q [SYNC];
  logic [PW-1:0]  sync_d [SYNC];
  logic [PW-1:0]  prev_q, prev_d;
  logic [PW-1:0]  out_q, out_d;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] ie_q, ie_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;

  logic [PW-1:0]  sync_last;
  logic [NCH-1:0] chg;
  logic [NCH-1:0] sel_dec;
  logic           sel_ok;

  assign sync_last = sync_q[SYNC-1];
  // Out-of-range selects decode to no channel at all.
  assign sel_ok    = (32'(sel) < NCH);

  // Per-channel change detect and one-hot select decode
  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign chg[i]     = (sync_last[i*DW +: DW] != prev_q[i*DW +: DW]);
    assign sel_dec[i] = sel_ok && (32'(sel) == i);
  end

  // Synchroniser shift chain: stage 0 samples the raw pins
  always_comb begin
    sync_d[0] = port_in;
    for (int s = 1; s < SYNC; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // Next-state for change history, pending flags, read/write paths and mask
  always_comb begin
    prev_d     = sync_last;
    // A new change sets the flag even when a read clears it on the same edge.
    pend_d     = chg | (pend_q & ~({NCH{rd_en}} & sel_dec));
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    out_d      = out_q;
    ie_d       = ie_wr ? ie_data : ie_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int i = 0; i < NCH; i++) begin
        if (sel_dec[i]) rd_data_d = sync_last[i*DW +: DW];
      end
    end
    if (wr_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (sel_dec[i]) out_d[i*DW +: DW] = wr_data;
      end
    end
  end

  // State registers, cleared immediately while rst is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < SYNC; s++) begin
        sync_q[s] <= '0;
      end
      prev_q     <= '0;
      out_q      <= '0;
      pend_q     <= '0;
      ie_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      for (int s = 0; s < SYNC; s++) begin
        sync_q[s] <= sync_d[s];
      end
      prev_q     <= prev_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      ie_q       <= ie_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign port_out = out_q;
  assign pend     = pend_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = |(pend_q & ie_q);

endmodule
`default_nettype wire

// File: tb/tb_slug_ports.sv
`default_nettype none
// ============================================================================
// Module   : tb_slug_ports
// Purpose  : Self-checking bench for slug_ports. The default instance has
//            eight channels. A six-channel instance shares the same stimulus
//            so that select values 6 and 7 are out of range for it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_slug_ports;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  sel = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_data = '0;
  logic        rd_en = 1'b0;
  logic        ie_wr = 1'b0;
  logic [7:0]  ie_data = '0;
  logic [31:0] port_in = '0;

  logic [3:0]  rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic [31:0] port_out0;
  logic [23:0] port_out1;
  logic [7:0]  pend0;
  logic [5:0]  pend1;
  logic        irq0, irq1;

  int checks = 0;
  int errors = 0;

  slug_ports #(.DW(4), .NCH(8), .SYNC(2)) u_dut0 (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .rd_valid(rd_valid0),
    .ie_wr(ie_wr), .ie_data(ie_data), .port_in(port_in),
    .port_out(port_out0), .pend(pend0), .irq(irq0)
  );

  slug_ports #(.DW(4), .NCH(6), .SYNC(2)) u_dut1 (
    .clk(clk), .rst(rst), .sel(sel), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .ie_wr(ie_wr), .ie_data(ie_data[5:0]), .port_in(port_in[23:0]),
    .port_out(port_out1), .pend(pend1), .irq(irq1)
  );

  always #5 clk = ~clk;

  // Reference model state, one entry per instance
  logic [31:0] m_s1 [2];
  logic [31:0] m_s2 [2];
  logic [31:0] m_prev [2];
  logic [31:0] m_out [2];
  logic [7:0]  m_pend [2];
  logic [7:0]  m_ie [2];
  logic [3:0]  m_rd [2];
  logic [3:0]  sb0 [$];
  logic [3:0]  sb1 [$];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_prev[k] = '0; m_out[k] = '0;
      m_pend[k] = '0; m_ie[k] = '0; m_rd[k] = '0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  initial clear_model();

  always @(negedge rst) clear_model();

  // Model: inputs reach the comparison point after two samples; any
  // difference from the previous sample raises the flag, reads clear it.
  always @(posedge clk) begin
    if (!rst) begin
      clear_model();
    end else begin
      for (int k = 0; k < 2; k++) begin
        int          n;
        int          s;
        logic [31:0] msk;
        logic [7:0]  np;
        logic [3:0]  rv;
        n   = (k == 0) ? 8 : 6;
        msk = (k == 0) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
        s   = int'(sel);
        np  = '0;
        for (int i = 0; i < n; i++) begin
          np[i] = (m_s2[k][i*4 +: 4] != m_prev[k][i*4 +: 4]) ||
                  (m_pend[k][i] && !(rd_en && s == i));
        end
        if (rd_en) begin
          rv = (s < n) ? m_s2[k][s*4 +: 4] : 4'h0;
          m_rd[k] = rv;
          if (k == 0) sb0.push_back(rv);
          else        sb1.push_back(rv);
        end
        if (wr_en && s < n) m_out[k][s*4 +: 4] = wr_data;
        if (ie_wr) m_ie[k] = ie_data & ((k == 0) ? 8'hFF : 8'h3F);
        m_pend[k] = np;
        m_prev[k] = m_s2[k];
        m_s2[k]   = m_s1[k];
        m_s1[k]   = port_in & msk;
      end
    end
  end

  // Monitor: compares every output on the falling edge and drains the
  // read scoreboards whenever rd_valid is presented.
  always @(negedge clk) begin
    check("port_out0", 64'(port_out0), 64'(m_out[0]));
    check("port_out1", 64'(port_out1), 64'(m_out[1][23:0]));
    check("pend0", 64'(pend0), 64'(m_pend[0]));
    check("pend1", 64'(pend1), 64'(m_pend[1][5:0]));
    check("irq0", 64'(irq0), 64'(|(m_pend[0] & m_ie[0])));
    check("irq1", 64'(irq1), 64'(|(m_pend[1] & m_ie[1])));
    check("rd_data0", 64'(rd_data0), 64'(m_rd[0]));
    check("rd_data1", 64'(rd_data1), 64'(m_rd[1]));
    if (rd_valid0) begin
      if (sb0.size() == 0) check("rd_valid0_spurious", 64'(1), 64'(0));
      else check("rd_scb0", 64'(rd_data0), 64'(sb0.pop_front()));
    end else if (sb0.size() != 0) begin
      check("rd_valid0_missing", 64'(0), 64'(1));
      sb0.delete();
    end
    if (rd_valid1) begin
      if (sb1.size() == 0) check("rd_valid1_spurious", 64'(1), 64'(0));
      else check("rd_scb1", 64'(rd_data1), 64'(sb1.pop_front()));
    end else if (sb1.size() != 0) begin
      check("rd_valid1_missing", 64'(0), 64'(1));
      sb1.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rd_en = 1'b0;
    ie_wr = 1'b0;
  endtask

  initial begin
    logic [5:0] pend1_before;

    // Reset held low
    step(); step();
    check("rst_port_out", 64'(port_out0), 64'(0));
    check("rst_pend", 64'(pend0), 64'(0));
    check("rst_irq", 64'(irq0), 64'(0));
    check("rst_rd_valid", 64'(rd_valid0), 64'(0));
    rst = 1'b1;

    // Write path
    sel = 3'd3; wr_data = 4'hA; wr_en = 1'b1;
    step();
    check("wr_sel3", 64'(port_out0), 64'h0000_A000);
    check("wr_sel3_inst1", 64'(port_out1), 64'h00_A000);
    sel = 3'd7; wr_data = 4'h5;
    step();
    check("wr_oor_inst1", 64'(port_out1), 64'h00_A000);
    idle();

    // Change detect, read clears pending
    port_in = 32'h0000_0050; ie_wr = 1'b1; ie_data = 8'h02;
    step(); idle();
    step();
    check("chg_not_yet", 64'(pend0), 64'(0));
    step();
    check("chg_pend", 64'(pend0), 64'h02);
    check("chg_irq", 64'(irq0), 64'(1));
    rd_en = 1'b1; sel = 3'd1;
    step(); idle();
    check("rd_data_ch1", 64'(rd_data0), 64'h5);
    check("rd_valid_ch1", 64'(rd_valid0), 64'(1));
    check("rd_clear_pend", 64'(pend0), 64'(0));
    check("rd_clear_irq", 64'(irq0), 64'(0));
    step();
    check("rd_valid_drop", 64'(rd_valid0), 64'(0));
    check("rd_data_hold", 64'(rd_data0), 64'h5);

    // Set wins over clear on the same edge
    port_in = 32'h0000_0350;
    step(); step();
    rd_en = 1'b1; sel = 3'd2;
    step();
    check("collide_pend2", 64'(pend0[2]), 64'(1));
    check("collide_rd", 64'(rd_data0), 64'h3);
    step(); idle();
    check("collide_clear", 64'(pend0[2]), 64'(0));

    // Out-of-range read on the six-channel instance
    pend1_before = pend1;
    rd_en = 1'b1; sel = 3'd7;
    step(); idle();
    check("oor_rd_data", 64'(rd_data1), 64'(0));
    check("oor_rd_valid", 64'(rd_valid1), 64'(1));
    check("oor_pend", 64'(pend1), 64'(pend1_before));

    // Mask gating, then mask update takes effect immediately
    ie_wr = 1'b1; ie_data = 8'h00; port_in = 32'h0000_0351;
    step(); idle();
    step(); step();
    check("mask_pend0", 64'(pend0[0]), 64'(1));
    check("mask_irq_off", 64'(irq0), 64'(0));
    ie_wr = 1'b1; ie_data = 8'h01;
    step(); idle();
    check("mask_irq_on", 64'(irq0), 64'(1));

    // Reset mid-run
    port_in = 32'hFFFF_FFFF;
    wr_data = 4'hF; wr_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step();
    end
    idle();
    check("pre_rst_pend", 64'(pend0), 64'hFF);
    check("pre_rst_out", 64'(port_out0), 64'hFFFF_FFFF);
    rd_en = 1'b1; sel = 3'd0;
    step(); idle();
    #2 rst = 1'b0;
    #1;
    check("arst_port_out", 64'(port_out0), 64'(0));
    check("arst_pend", 64'(pend0), 64'(0));
    check("arst_irq", 64'(irq0), 64'(0));
    check("arst_rd_valid", 64'(rd_valid0), 64'(0));
    check("arst_rd_data", 64'(rd_data0), 64'(0));
    port_in = 32'h0000_0010;
    step(); step();
    rst = 1'b1;
    step(); step();
    check("rel_pend_early", 64'(pend0), 64'(0));
    step();
    check("rel_pend", 64'(pend0), 64'h02);
    check("rel_pend_inst1", 64'(pend1), 64'h02);

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      sel     = 3'($urandom_range(0, 7));
      wr_en   = 1'($urandom_range(0, 1));
      wr_data = 4'($urandom);
      rd_en   = 1'($urandom_range(0, 1));
      ie_wr   = ($urandom_range(0, 7) == 0);
      ie_data = 8'($urandom);
      if ($urandom_range(0, 3) == 0) port_in = $urandom;
      step();
    end
    idle();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
